stream_demux: RTL and testbench

- Registered 1-to-N stream demultiplexer; the distribution counterpart of the team's registered N-to-1 select mux.
- Routes one valid/ready input stream to one of OUTPUT_COUNT output channels, chosen per beat by in_sel.
- Each output channel has a one-entry holding register with its own valid/ready handshake, so a stalled channel blocks only beats addressed to it.
- Sits between a shared producer (e.g. an arbiter or mux output) and independent per-lane consumers.

---
 rtl/stream_demux_if.sv | 36 +++
 rtl/stream_demux.sv | 111 +++++++++++
 tb/tb_stream_demux.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stream_demux_if
//  Purpose  : Bundles the input stream, the per-channel output streams and the
//             status outputs of stream_demux.
//             master = producer/consumer side, slave = demux side.
//  Revision : 1.0 - initial release
// ============================================================================
interface stream_demux_if #(
  parameter int OUTPUT_COUNT = 8,
  parameter int DATA_WIDTH   = 32
);
  localparam int SEL_W = $clog2(OUTPUT_COUNT);

  logic                               in_valid;
  logic                               in_ready;
  logic [DATA_WIDTH-1:0]              in_data;
  logic [SEL_W-1:0]                   in_sel;
  logic [OUTPUT_COUNT-1:0]            out_valid;
  logic [OUTPUT_COUNT-1:0]            out_ready;
  logic [OUTPUT_COUNT*DATA_WIDTH-1:0] out_data;
  logic                               err_sel;
  logic [OUTPUT_COUNT*16-1:0]         stat_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, err_sel, stat_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, err_sel, stat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/stream_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stream_demux
//  Purpose  : Registered 1-to-OUTPUT_COUNT stream demultiplexer. Each output
//             channel owns a one-entry holding register, so a stalled channel
//             only blocks beats addressed to it. Beats with an out-of-range
//             select are accepted, dropped and flagged on err_sel.
//  Options  : STREAM_DEMUX_STATS_EN - builds 16-bit saturating per-channel
//             delivered-beat counters on stat_cnt (tied to 0 otherwise).
//  Revision : 1.0 - initial release
// ============================================================================
module stream_demux #(
  parameter int OUTPUT_COUNT = 8,
  parameter int DATA_WIDTH   = 32
) (
  input  wire            clk,
  input  wire            rst,
  stream_demux_if.slave  bus
);
  localparam int SEL_W = $clog2(OUTPUT_COUNT);

  logic [OUTPUT_COUNT-1:0]                 valid_q, valid_d;
  logic [OUTPUT_COUNT-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic                                    err_q, err_d;

  logic                    sel_legal;
  logic                    sel_busy;
  logic                    accept;
  logic [OUTPUT_COUNT-1:0] load;
  logic [OUTPUT_COUNT-1:0] drain;

  // Select decode: is the addressed channel full and not being drained?
  // Scanning all channels avoids indexing past the end for out-of-range selects.
  always_comb begin
    sel_legal = int'(bus.in_sel) < OUTPUT_COUNT;
    sel_busy  = 1'b0;
    for (int k = 0; k < OUTPUT_COUNT; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_busy = valid_q[k] & ~bus.out_ready[k];
      end
    end
  end

  // Out-of-range beats are always accepted so the producer never deadlocks.
  assign bus.in_ready = ~sel_legal | ~sel_busy;
  assign accept       = bus.in_valid & bus.in_ready;
  assign drain        = valid_q & bus.out_ready;

  // Next-state for the holding registers: load wins over drain so a channel
  // can be refilled in the same cycle it empties (1 beat/cycle per channel).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    load    = '0;
    err_d   = accept & ~sel_legal;
    for (int k = 0; k < OUTPUT_COUNT; k++) begin
      load[k]    = accept & sel_legal & (bus.in_sel == SEL_W'(k));
      valid_d[k] = load[k] | (valid_q[k] & ~drain[k]);
      if (load[k]) begin
        data_d[k] = bus.in_data;
      end
    end
  end

  // Holding registers and error pulse; idle slices keep their last payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.err_sel   = err_q;

`ifdef STREAM_DEMUX_STATS_EN
  logic [OUTPUT_COUNT-1:0][15:0] cnt_q, cnt_d;

  // Count drains per channel, sticking at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < OUTPUT_COUNT; k++) begin
      if (drain[k] && (cnt_q[k] != 16'hFFFF)) begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.stat_cnt = cnt_q;
`else
  assign bus.stat_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_stream_demux
//  Purpose  : Self-checking bench for stream_demux. Drives an 8-channel and a
//             6-channel instance; a per-channel holding-slot model predicts
//             every output each cycle, and directed vectors pin down the
//             documented corner cases.
//  Options  : STREAM_DEMUX_STATS_EN - expects saturating counters on stat_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demux;

`ifdef STREAM_DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;

  stream_demux_if #(.OUTPUT_COUNT(8), .DATA_WIDTH(32)) bus8 ();
  stream_demux_if #(.OUTPUT_COUNT(6), .DATA_WIDTH(32)) bus6 ();

  stream_demux #(.OUTPUT_COUNT(8), .DATA_WIDTH(32)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  stream_demux #(.OUTPUT_COUNT(6), .DATA_WIDTH(32)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus for both instances (index 0: 8 channels, index 1: 6 channels).
  logic        ivalid [2];
  logic [31:0] idata  [2];
  logic [2:0]  isel   [2];
  logic [7:0]  irdy   [2];

  // Reference model: one holding slot per channel plus drain counters.
  logic        mv    [2][8];
  logic [31:0] md    [2][8];
  logic [15:0] mc    [2][8];
  logic        me    [2];
  logic        stall [2];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        v;
    logic [31:0] data;
    logic [2:0]  sel;
    logic [7:0]  rdy;
    logic        e_rdy;
    logic [7:0]  e_valid;
    int          ch;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic logic [31:0] s8(input int ch);
    return bus8.out_data[ch*32 +: 32];
  endfunction

  function automatic logic [31:0] s6(input int ch);
    return bus6.out_data[ch*32 +: 32];
  endfunction

  function automatic bit pred_ready(input int d);
    if (int'(isel[d]) >= nch(d)) return 1'b1;
    return !mv[d][isel[d]] || irdy[d][isel[d]];
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      me[d]    = 1'b0;
      stall[d] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        mv[d][k] = 1'b0;
        md[d][k] = '0;
        mc[d][k] = '0;
      end
    end
  endtask

  task automatic apply();
    bus8.in_valid  = ivalid[0];
    bus8.in_data   = idata[0];
    bus8.in_sel    = isel[0];
    bus8.out_ready = irdy[0];
    bus6.in_valid  = ivalid[1];
    bus6.in_data   = idata[1];
    bus6.in_sel    = isel[1];
    bus6.out_ready = irdy[1][5:0];
  endtask

  task automatic idle(input int d);
    ivalid[d] = 1'b0;
    idata[d]  = '0;
    isel[d]   = '0;
    irdy[d]   = 8'hFF;
  endtask

  // Compare every output of instance d against the model (called mid-cycle).
  task automatic model_check(input int d);
    logic [7:0]   ev, av;
    logic [255:0] ed, ad;
    logic [127:0] es, ast;
    logic         er, ar, ae;
    ev = '0; ed = '0; es = '0;
    for (int k = 0; k < nch(d); k++) begin
      ev[k]           = mv[d][k];
      ed[k*32 +: 32]  = md[d][k];
      es[k*16 +: 16]  = mc[d][k];
    end
    er = pred_ready(d);
    if (d == 0) begin
      av = bus8.out_valid; ad = bus8.out_data; ast = bus8.stat_cnt;
      ar = bus8.in_ready;  ae = bus8.err_sel;
    end else begin
      av = {2'b00, bus6.out_valid}; ad = {64'h0, bus6.out_data};
      ast = {32'h0, bus6.stat_cnt}; ar = bus6.in_ready; ae = bus6.err_sel;
    end
    chk($sformatf("model%0d_in_ready", d),  ar,  er);
    chk($sformatf("model%0d_out_valid", d), av,  ev);
    chk($sformatf("model%0d_out_data", d),  ad,  ed);
    chk($sformatf("model%0d_err_sel", d),   ae,  me[d]);
    chk($sformatf("model%0d_stat_cnt", d),  ast, es);
    stall[d] = ivalid[d] && !er;
  endtask

  // Advance the model across one clock edge using the spec's rules.
  task automatic model_update(input int d);
    bit acc, drn;
    if (rst) begin
      me[d] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        mv[d][k] = 1'b0; md[d][k] = '0; mc[d][k] = '0;
      end
      return;
    end
    acc   = ivalid[d] && pred_ready(d);
    me[d] = acc && (int'(isel[d]) >= nch(d));
    for (int k = 0; k < nch(d); k++) begin
      drn = mv[d][k] && irdy[d][k];
      if (STATS && drn && mc[d][k] != 16'hFFFF) mc[d][k] = mc[d][k] + 16'd1;
      if (acc && int'(isel[d]) == k) begin
        mv[d][k] = 1'b1;
        md[d][k] = idata[d];
      end else if (drn) begin
        mv[d][k] = 1'b0;
      end
    end
  endtask

  task automatic finish_cycle();
    model_check(0);
    model_check(1);
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic step();
    apply();
    @(negedge clk);
    finish_cycle();
  endtask

  // Asynchronous reset pulse placed away from the clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_clear();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1 rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ncyc;

    // Directed vectors, observed mid-cycle before each row's edge.
    tbl[0] = '{1'b1, 32'hA5A5_0001, 3'd3, 8'hFF, 1'b1, 8'h00, 3, 32'h0};
    tbl[1] = '{1'b0, 32'h0,         3'd0, 8'hFF, 1'b1, 8'h08, 3, 32'hA5A5_0001};
    tbl[2] = '{1'b0, 32'h0,         3'd0, 8'hFF, 1'b1, 8'h00, 3, 32'hA5A5_0001};
    tbl[3] = '{1'b1, 32'h11,        3'd5, 8'hDF, 1'b1, 8'h00, 5, 32'h0};
    tbl[4] = '{1'b1, 32'h22,        3'd5, 8'hDF, 1'b0, 8'h20, 5, 32'h11};
    tbl[5] = '{1'b1, 32'h33,        3'd1, 8'hDF, 1'b1, 8'h20, 5, 32'h11};
    tbl[6] = '{1'b1, 32'h22,        3'd5, 8'hDF, 1'b0, 8'h22, 1, 32'h33};
    tbl[7] = '{1'b1, 32'h22,        3'd5, 8'hFF, 1'b1, 8'h20, 5, 32'h11};
    tbl[8] = '{1'b0, 32'h0,         3'd0, 8'hFF, 1'b1, 8'h20, 5, 32'h22};
    tbl[9] = '{1'b0, 32'h0,         3'd0, 8'hFF, 1'b1, 8'h00, 5, 32'h22};

    rst = 1'b1;
    idle(0);
    idle(1);
    apply();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid8", bus8.out_valid, 8'h00);
    chk("reset_out_data8",  bus8.out_data,  256'h0);
    chk("reset_err_sel8",   bus8.err_sel,   1'b0);
    chk("reset_stat_cnt8",  bus8.stat_cnt,  128'h0);
    chk("reset_out_valid6", bus6.out_valid, 6'h00);
    @(posedge clk);
    #1 rst = 1'b0;

    // Park a beat in ch2, then reset asynchronously mid-cycle.
    ivalid[0] = 1'b1; isel[0] = 3'd2; idata[0] = 32'hC0DE_0002; irdy[0] = 8'hFB;
    step();
    ivalid[0] = 1'b0;
    apply();
    #2;
    chk("pre_reset_valid", bus8.out_valid, 8'h04);
    rst = 1'b1;
    #1;
    chk("async_reset_valid", bus8.out_valid, 8'h00);
    chk("async_reset_data",  bus8.out_data,  256'h0);
    model_clear();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1 rst = 1'b0;

    // Basic route and backpressure isolation vectors.
    for (int r = 0; r < 10; r++) begin
      ivalid[0] = tbl[r].v;   idata[0] = tbl[r].data;
      isel[0]   = tbl[r].sel; irdy[0]  = tbl[r].rdy;
      idle(1);
      apply();
      @(negedge clk);
      chk($sformatf("row%0d_in_ready", r),  bus8.in_ready,  tbl[r].e_rdy);
      chk($sformatf("row%0d_out_valid", r), bus8.out_valid, tbl[r].e_valid);
      chk($sformatf("row%0d_ch%0d_data", r, tbl[r].ch), s8(tbl[r].ch), tbl[r].e_data);
      finish_cycle();
    end

    // Streaming: 16 back-to-back beats into ch0.
    for (int i = 0; i < 16; i++) begin
      ivalid[0] = 1'b1; isel[0] = 3'd0; idata[0] = 32'h1000 + i; irdy[0] = 8'hFF;
      apply();
      @(negedge clk);
      chk($sformatf("stream%0d_in_ready", i), bus8.in_ready, 1'b1);
      if (i > 0) begin
        chk($sformatf("stream%0d_valid0", i), bus8.out_valid[0], 1'b1);
        chk($sformatf("stream%0d_data0", i),  s8(0), 32'h1000 + i - 1);
      end
      finish_cycle();
    end

    // Round-robin: one beat per channel, data = sel * 0x100.
    for (int i = 0; i < 9; i++) begin
      ivalid[0] = (i < 8); isel[0] = 3'(i); idata[0] = 32'h100 * i; irdy[0] = 8'hFF;
      apply();
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("rr%0d_valid", i), bus8.out_valid, 8'h01 << (i - 1));
        chk($sformatf("rr%0d_data", i),  s8(i - 1), 32'h100 * (i - 1));
      end
      finish_cycle();
    end
    idle(0);

    // Out-of-range select on the 6-channel instance, with ch2 held.
    ivalid[1] = 1'b1; isel[1] = 3'd2; idata[1] = 32'hBEEF; irdy[1] = 8'hFB;
    step();
    isel[1] = 3'd7; idata[1] = 32'hDEAD;
    apply();
    @(negedge clk);
    chk("oor_in_ready",   bus6.in_ready,  1'b1);
    chk("oor_err_before", bus6.err_sel,   1'b0);
    chk("oor_valid_a",    bus6.out_valid, 6'h04);
    finish_cycle();
    ivalid[1] = 1'b0;
    apply();
    @(negedge clk);
    chk("oor_err_pulse", bus6.err_sel,   1'b1);
    chk("oor_valid_b",   bus6.out_valid, 6'h04);
    chk("oor_ch2_data",  s6(2),          32'hBEEF);
    finish_cycle();
    apply();
    @(negedge clk);
    chk("oor_err_after", bus6.err_sel, 1'b0);
    finish_cycle();

    // Randomized traffic on both instances; stalled beats are held stable.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (!stall[d]) begin
          ivalid[d] = ($urandom_range(0, 3) != 0);
          isel[d]   = 3'($urandom_range(0, 7));
          idata[d]  = $urandom;
        end
        irdy[d] = 8'($urandom) | 8'($urandom);
      end
      step();
    end

    // Drain counters: continuous traffic on ch4 from a clean reset.
    idle(0);
    idle(1);
    apply();
    do_reset();
    ncyc = STATS ? 70000 : 300;
    for (int i = 0; i < ncyc; i++) begin
      ivalid[0] = 1'b1; isel[0] = 3'd4; idata[0] = i; irdy[0] = 8'hFF;
      step();
    end
    @(negedge clk);
    chk("stat_ch4",    bus8.stat_cnt[4*16 +: 16], STATS ? 16'hFFFF : 16'h0);
    chk("stat_others", bus8.stat_cnt & ~(128'hFFFF << 64), 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
